// File: rtl/router_out_client.sv
// router_out_client: reads one packet at a time from a router output FIFO, streams payload, checks parity
module router_out_client #(
  parameter logic [1:0] PORT_ADDR   = 2'd0,
  parameter int         START_DELAY = 2,
  parameter int         TIMEOUT     = 32
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       vld_out,
  input  logic [7:0] data_out,
  input  logic       out_ready,
  output logic       read_enb,
  output logic       out_valid,
  output logic [7:0] out_data,
  output logic       out_sop,
  output logic       out_eop,
  output logic [5:0] pkt_len,
  output logic [1:0] pkt_addr,
  output logic       pkt_done,
  output logic       parity_err,
  output logic       addr_err,
  output logic       pkt_abort,
  output logic       busy
);
  typedef enum logic [2:0] {IDLE, WAIT, HDR, HDR_WAIT, BODY, DRAIN, CHECK} state_t;
  state_t     state, state_n;
  logic       rd_pend;
  logic [3:0] dly_cnt;
  logic [5:0] to_cnt;
  logic [6:0] remain;
  logic [6:0] got;
  logic [7:0] acc;
  logic       timed;
  logic       cap;
  assign timed      = (state == HDR) || (state == BODY);
  assign pkt_abort  = timed && !vld_out && (to_cnt == 6'(TIMEOUT - 1));
  assign cap        = rd_pend && ((state == BODY) || (state == DRAIN)) && !pkt_abort;
  assign pkt_done   = state == CHECK;
  assign parity_err = pkt_done && (acc != 8'd0);
  assign addr_err   = pkt_done && (pkt_addr != PORT_ADDR);
  assign busy       = state != IDLE;
  // Next-state and read strobe; the accumulator also folds in the parity byte, so a clean packet leaves it zero
  always_comb begin
    state_n  = state;
    read_enb = 1'b0;
    case (state)
      IDLE:     if (vld_out) state_n = (START_DELAY == 0) ? HDR : WAIT;
      WAIT:     if (dly_cnt + 4'd1 == 4'(START_DELAY)) state_n = HDR;
      HDR: begin
        read_enb = vld_out;
        if (vld_out) state_n = HDR_WAIT;
      end
      HDR_WAIT: state_n = BODY;
      BODY: begin
        read_enb = vld_out && out_ready && (remain != 7'd0);
        if (read_enb && remain == 7'd1) state_n = DRAIN;
      end
      DRAIN:    state_n = CHECK;
      CHECK:    state_n = IDLE;
      default:  state_n = IDLE;
    endcase
    if (pkt_abort) state_n = IDLE;
  end
  // State, counters, header capture and registered payload presentation
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      rd_pend   <= 1'b0;
      dly_cnt   <= '0;
      to_cnt    <= '0;
      remain    <= '0;
      got       <= '0;
      acc       <= '0;
      pkt_len   <= '0;
      pkt_addr  <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sop   <= 1'b0;
      out_eop   <= 1'b0;
    end else begin
      state     <= state_n;
      rd_pend   <= read_enb;
      dly_cnt   <= (state == WAIT) ? dly_cnt + 4'd1 : 4'd0;
      to_cnt    <= (timed && !vld_out && !pkt_abort) ? to_cnt + 6'd1 : 6'd0;
      out_valid <= 1'b0;
      out_sop   <= 1'b0;
      out_eop   <= 1'b0;
      if (state == HDR_WAIT) begin
        pkt_len  <= data_out[7:2];
        pkt_addr <= data_out[1:0];
        acc      <= data_out;
        remain   <= {1'b0, data_out[7:2]} + 7'd1;
        got      <= '0;
      end else if (state == BODY && read_enb) begin
        remain <= remain - 7'd1;
      end
      if (cap) begin
        acc <= acc ^ data_out;
        got <= got + 7'd1;
        if (got < {1'b0, pkt_len}) begin
          out_valid <= 1'b1;
          out_data  <= data_out;
          out_sop   <= got == 7'd0;
          out_eop   <= got == {1'b0, pkt_len} - 7'd1;
        end
      end
    end
  end
endmodule

// File: tb/tb_router_out_client.sv
// tb_router_out_client: FIFO-fed directed packets checked against a payload/result scoreboard
module tb_router_out_client;
  logic       clock, resetn, vld_out, out_ready;
  logic [7:0] data_out;
  logic       read_enb, out_valid, out_sop, out_eop, pkt_done, parity_err, addr_err, pkt_abort, busy;
  logic [7:0] out_data;
  logic [5:0] pkt_len;
  logic [1:0] pkt_addr;
  int         cyc, c0, n_chk, n_fail, abort_cnt;
  logic [7:0] fifo[$];
  logic [9:0] exp_q[$];
  logic [9:0] exp_pkt[$];
  int         rd_log[$], ov_log[$], done_log[$];
  logic       rd_q, rdy, drop;
  logic [9:0] e, ep;

  router_out_client #(.PORT_ADDR(2'd0), .START_DELAY(0), .TIMEOUT(32)) dut (
    .clock(clock), .resetn(resetn), .vld_out(vld_out), .data_out(data_out), .out_ready(out_ready),
    .read_enb(read_enb), .out_valid(out_valid), .out_data(out_data), .out_sop(out_sop), .out_eop(out_eop),
    .pkt_len(pkt_len), .pkt_addr(pkt_addr), .pkt_done(pkt_done), .parity_err(parity_err),
    .addr_err(addr_err), .pkt_abort(pkt_abort), .busy(busy)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // one clock: sample the read strobe, then the FIFO model answers it and new inputs are applied
  task automatic step();
    @(negedge clock);
    rd_q = read_enb;
    @(posedge clock);
    #1;
    cyc++;
    if (rd_q && fifo.size() != 0) data_out = fifo.pop_front();
    vld_out   = (fifo.size() != 0) && !drop;
    out_ready = rdy;
  endtask

  task automatic send(input int len, input logic [1:0] addr, input logic flip);
    logic [7:0] b, par, hdr;
    hdr = {6'(len), addr};
    par = hdr;
    fifo.push_back(hdr);
    for (int i = 0; i < len; i++) begin
      b = (i < 3) ? 8'(8'h11 * (i + 1)) : 8'($urandom);
      par ^= b;
      fifo.push_back(b);
      exp_q.push_back({i == 0, i == len - 1, b});
    end
    fifo.push_back(par ^ {7'd0, flip});
    exp_pkt.push_back({6'(len), addr, flip, addr != 2'd0});
    rd_log.delete();
    ov_log.delete();
    done_log.delete();
    step();
    c0 = cyc;
  endtask

  // runs until pkt_done; out_ready low in cycles c0+rlo..c0+rhi, vld_out dropped in c0+dlo..c0+dhi
  task automatic wait_done(input int rlo, input int rhi, input int dlo, input int dhi, input int extra, input int len);
    for (int k = 0; k < 300 && done_log.size() == 0; k++) begin
      int n;
      n    = cyc + 1 - c0;
      rdy  = !(n >= rlo && n <= rhi);
      drop = n >= dlo && n <= dhi;
      step();
    end
    rdy  = 1'b1;
    drop = 1'b0;
    check("done_seen", done_log.size(), 1);
    check("done_cycle", done_log[0] - c0, 5 + len + extra);
    step();
    step();
    check("busy_after", busy, 0);
    check("payload_all_seen", exp_q.size(), 0);
  endtask

  // scoreboard compare on every falling edge
  always @(negedge clock) begin
    if (resetn) begin
      if (read_enb) begin
        rd_log.push_back(cyc);
        check("read_needs_vld", vld_out, 1);
      end
      if (out_valid) begin
        ov_log.push_back(cyc);
        check("ov_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("payload", {out_sop, out_eop, out_data}, e);
        end
      end
      if (pkt_done) begin
        done_log.push_back(cyc);
        check("done_expected", exp_pkt.size() != 0, 1);
        if (exp_pkt.size() != 0) begin
          ep = exp_pkt.pop_front();
          check("pkt_result", {pkt_len, pkt_addr, parity_err, addr_err}, ep);
        end
      end
      if (pkt_abort) abort_cnt++;
    end
  end

  initial begin
    cyc = 0; n_chk = 0; n_fail = 0; abort_cnt = 0;
    rd_q = 1'b0; rdy = 1'b1; drop = 1'b0;
    vld_out = 1'b0; data_out = 8'd0; out_ready = 1'b1;
    resetn = 1'b1;
    #1 resetn = 1'b0;
    #1;
    check("rst_read_enb", read_enb, 0);
    check("rst_busy", busy, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_pkt_len", pkt_len, 0);
    check("rst_pkt_done", pkt_done, 0);
    check("rst_pkt_abort", pkt_abort, 0);
    step();
    step();
    resetn = 1'b1;
    step();
    step();
    // L=3 reference packet with literal timing
    send(3, 2'd0, 1'b0);
    wait_done(1, 0, 1, 0, 0, 3);
    check("t1_nreads", rd_log.size(), 5);
    check("t1_rd_hdr", rd_log[0], c0 + 1);
    check("t1_rd_p1", rd_log[1], c0 + 3);
    check("t1_rd_par", rd_log[4], c0 + 6);
    check("t1_nvalid", ov_log.size(), 3);
    check("t1_ov_first", ov_log[0], c0 + 5);
    check("t1_ov_last", ov_log[2], c0 + 7);
    check("t1_done", done_log[0], c0 + 8);
    check("t1_len_held", pkt_len, 3);
    // corrupted parity, then wrong address
    send(3, 2'd0, 1'b1);
    wait_done(1, 0, 1, 0, 0, 3);
    send(3, 2'd3, 1'b0);
    wait_done(1, 0, 1, 0, 0, 3);
    check("t3_addr_held", pkt_addr, 3);
    // L=0 and L=1
    send(0, 2'd0, 1'b0);
    wait_done(1, 0, 1, 0, 0, 0);
    check("l0_nreads", rd_log.size(), 2);
    check("l0_nvalid", ov_log.size(), 0);
    check("l0_done", done_log[0], c0 + 5);
    send(1, 2'd0, 1'b0);
    wait_done(1, 0, 1, 0, 0, 1);
    check("l1_nvalid", ov_log.size(), 1);
    // L=63
    send(63, 2'd0, 1'b0);
    wait_done(1, 0, 1, 0, 0, 63);
    check("l63_nvalid", ov_log.size(), 63);
    check("l63_done", done_log[0], c0 + 68);
    // L=4 with 3 out_ready stall cycles and 2 vld_out dropout cycles
    send(4, 2'd0, 1'b0);
    wait_done(5, 7, 10, 11, 5, 4);
    check("stall_nreads", rd_log.size(), 6);
    check("stall_done", done_log[0], c0 + 14);
    // header only, FIFO runs dry: timeout abort
    fifo.push_back({6'd3, 2'd0});
    rd_log.delete();
    done_log.delete();
    step();
    c0 = cyc;
    for (int k = 0; k < 45; k++) step();
    check("abort_once", abort_cnt, 1);
    check("abort_no_done", done_log.size(), 0);
    check("abort_busy", busy, 0);
    check("abort_nreads", rd_log.size(), 1);
    send(5, 2'd0, 1'b0);
    wait_done(1, 0, 1, 0, 0, 5);
    // reset in the middle of the payload
    send(10, 2'd0, 1'b0);
    for (int k = 0; k < 20 && cyc < c0 + 6; k++) step();
    check("pre_reset_busy", busy, 1);
    #2 resetn = 1'b0;
    #1;
    check("mid_rst_read_enb", read_enb, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_out_data", out_data, 0);
    check("mid_rst_pkt_len", pkt_len, 0);
    check("mid_rst_pkt_addr", pkt_addr, 0);
    fifo.delete();
    exp_q.delete();
    exp_pkt.delete();
    vld_out = 1'b0;
    step();
    step();
    resetn = 1'b1;
    step();
    send(2, 2'd0, 1'b0);
    wait_done(1, 0, 1, 0, 0, 2);
    check("total_aborts", abort_cnt, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
